// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: cache line refill controller.
// On a lookup miss it picks a round-robin victim way and invalidates its tag.
// It then fetches the line over a valid/ready request and a beat stream,
// writes each beat into the data RAM and commits the new tag with its enable bit set.
// Optional feature macro: CACHE_REFILL_CWF_EN (critical-word-first fetch and forward).
module cache_refill_ctrl #(
  parameter int NUM_WAYS         = 1,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int CLINE_SIZE_WORD  = 4,
  parameter int CLINE_ADDR_WIDTH = 7,
  localparam int WOFF            = $clog2(CLINE_SIZE_WORD),
  localparam int TAG_OFFSET      = WOFF + CLINE_ADDR_WIDTH,
  localparam int TAG_WIDTH       = ADDR_WIDTH - TAG_OFFSET + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic                             hit_i,
  input  logic [NUM_WAYS-1:0]              way_hit_i,
  output logic                             busy_o,
  output logic                             mem_req_valid_o,
  input  logic                             mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
  input  logic                             mem_rsp_valid_i,
  output logic                             mem_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data_i,
  output logic [NUM_WAYS-1:0]              data_we_o,
  output logic [CLINE_ADDR_WIDTH+WOFF-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0]            data_wdata_o,
  output logic [NUM_WAYS-1:0]              tag_we_o,
  output logic [CLINE_ADDR_WIDTH-1:0]      tag_addr_o,
  output logic [TAG_WIDTH-1:0]             tag_wdata_o,
  output logic                             crit_valid_o,
  output logic                             done_o
);

  localparam int VIC_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [VIC_W-1:0] VIC_LAST = VIC_W'(NUM_WAYS - 1);
  localparam logic [WOFF-1:0]  BEAT_LAST = WOFF'(CLINE_SIZE_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INVAL,
    S_REQ,
    S_FILL,
    S_COMMIT
  } state_e;

  state_e                        state_q, state_d;
  logic [VIC_W-1:0]              vic_q, vic_d;
  logic [WOFF-1:0]               wcnt_q, wcnt_d;
  logic [WOFF-1:0]               bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;

  logic                          busy_q, busy_d;
  logic                          req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]         req_addr_q, req_addr_d;
  logic                          rsp_ready_q, rsp_ready_d;
  logic [NUM_WAYS-1:0]           tag_we_q, tag_we_d;
  logic [CLINE_ADDR_WIDTH-1:0]   tag_addr_q, tag_addr_d;
  logic [TAG_WIDTH-1:0]          tag_wdata_q, tag_wdata_d;
  logic                          done_q, done_d;

  logic                          beat_acc;
  logic [WOFF-1:0]               start_woff;
  logic [ADDR_WIDTH-1:0]         fetch_addr;
  logic                          crit;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [VIC_W-1:0] v);
    logic [NUM_WAYS-1:0] oh;
    for (int w = 0; w < NUM_WAYS; w++) begin
      oh[w] = (v == VIC_W'(w));
    end
    return oh;
  endfunction

  // A beat is consumed only while the response side is open (FILL).
  assign beat_acc = rsp_ready_q && mem_rsp_valid_i;

`ifdef CACHE_REFILL_CWF_EN
  assign start_woff = addr_i[WOFF-1:0];
  assign fetch_addr = addr_d;
  assign crit       = beat_acc && (bcnt_q == '0);
`else
  assign start_woff = '0;
  assign fetch_addr = {addr_d[ADDR_WIDTH-1:WOFF], {WOFF{1'b0}}};
  assign crit       = 1'b0;
`endif

  // Next-state logic plus the values the registered outputs take in the next state.
  always_comb begin
    state_d = state_q;
    vic_d   = vic_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (lookup_valid_i && !hit_i) begin
          addr_d  = addr_i;
          wcnt_d  = start_woff;
          bcnt_d  = '0;
          state_d = S_INVAL;
        end
      end
      S_INVAL: state_d = S_REQ;
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_FILL;
      end
      S_FILL: begin
        if (beat_acc) begin
          wcnt_d = wcnt_q + 1'b1;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BEAT_LAST) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        vic_d   = (vic_q == VIC_LAST) ? '0 : vic_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    req_valid_d = (state_d == S_REQ);
    req_addr_d  = req_valid_d ? fetch_addr : '0;
    rsp_ready_d = (state_d == S_FILL);
    tag_we_d    = '0;
    tag_addr_d  = '0;
    tag_wdata_d = '0;
    if (state_d == S_INVAL || state_d == S_COMMIT) begin
      tag_we_d    = way_onehot(vic_d);
      tag_addr_d  = addr_d[TAG_OFFSET-1:WOFF];
      tag_wdata_d = {(state_d == S_COMMIT), addr_d[ADDR_WIDTH-1:TAG_OFFSET]};
    end
    done_d = (state_d == S_COMMIT);
  end

  // Control state and registered outputs; reset aborts any refill in progress.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      vic_q       <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      rsp_ready_q <= 1'b0;
      tag_we_q    <= '0;
      tag_addr_q  <= '0;
      tag_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vic_q       <= vic_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      rsp_ready_q <= rsp_ready_d;
      tag_we_q    <= tag_we_d;
      tag_addr_q  <= tag_addr_d;
      tag_wdata_q <= tag_wdata_d;
      done_q      <= done_d;
    end
  end

  // Missed address; only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
  end

  assign busy_o          = busy_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_rsp_ready_o = rsp_ready_q;
  assign tag_we_o        = tag_we_q;
  assign tag_addr_o      = tag_addr_q;
  assign tag_wdata_o     = tag_wdata_q;
  assign done_o          = done_q;

  // Beat writes go straight through in the cycle the beat is accepted.
  assign data_we_o    = beat_acc ? way_onehot(vic_q) : '0;
  assign data_addr_o  = beat_acc ? {addr_q[TAG_OFFSET-1:WOFF], wcnt_q} : '0;
  assign data_wdata_o = beat_acc ? mem_rsp_data_i : '0;
  assign crit_valid_o = crit;

`ifndef SYNTHESIS
  // A reported hit must name exactly one way.
  always_ff @(posedge clk_i) begin
    if (rst_ni && lookup_valid_i && hit_i) begin
      assert ($onehot(way_hit_i));
    end
  end
`endif

endmodule
